// File: rtl/aes_pkg.sv
// Shared types for the AES multicore dispatch front-end.
package aes_pkg;
  localparam int AES_BLOCK_W = 128;

  typedef logic [AES_BLOCK_W-1:0] block_t;

  typedef enum logic {FILL, HOLD} in_state_e;
  typedef enum logic {IDLE, SEND} out_state_e;
endpackage

// File: rtl/aes_stream_ser.sv
// Shift-out of one 128-bit block as DATA_W-bit beats, LSB beat first, with valid/ready.
module aes_stream_ser
  import aes_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              load,
  input  block_t            block,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              last
);
  localparam int BEATS = AES_BLOCK_W / DATA_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  block_t           sh;
  logic [CNT_W-1:0] cnt;
  logic             hs;

  assign hs   = ce & valid & ready;
  assign last = hs && (cnt == CNT_W'(BEATS - 1));
  assign data = sh[DATA_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh    <= '0;
      cnt   <= '0;
      valid <= 1'b0;
    end else if (ce) begin
      if (load) begin
        sh    <= block;
        cnt   <= '0;
        valid <= 1'b1;
      end else if (hs) begin
        sh <= sh >> DATA_W;
        if (last) begin
          valid <= 1'b0;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/aes_multicore_dispatch.sv
// Deserialises stream beats into blocks, dispatches them round-robin to AES cores,
// and re-serialises core results in input order.
module aes_multicore_dispatch
  import aes_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_CORES = 4
) (
  input  logic                             CLK_I,
  input  logic                             RESET_I,
  input  logic                             CE_I,
  input  logic [DATA_W-1:0]                DATA_I,
  input  logic                             VALID_I,
  output logic                             READY_O,
  output logic [127:0]                     CORE_DATA_O,
  output logic [NUM_CORES-1:0]             CORE_START_O,
  input  logic [NUM_CORES-1:0]             CORE_BUSY_I,
  input  logic [NUM_CORES-1:0]             CORE_DONE_I,
  input  logic [NUM_CORES*128-1:0]         CORE_RESULT_I,
  output logic [DATA_W-1:0]                DATA_O,
  output logic                             VALID_O,
  input  logic                             READY_I,
  output logic [$clog2(NUM_CORES+1)-1:0]   OUTSTANDING_O,
  output logic                             ERR_O
);
  localparam int BEATS = AES_BLOCK_W / DATA_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int OUT_W = $clog2(NUM_CORES + 1);

  in_state_e              in_state;
  out_state_e             out_state;
  logic                   rdy_q;
  logic [CNT_W-1:0]       beat_cnt;
  block_t                 blk;
  block_t                 core_data_q;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [NUM_CORES-1:0]   inflight;
  logic [NUM_CORES-1:0]   pending;
  block_t                 slot [NUM_CORES];
  logic                   err_q;
  logic [OUT_W-1:0]       outstanding;
  logic                   acc;
  logic                   can_dispatch;
  logic                   dispatch;
  logic                   ser_load;
  logic                   ser_last;
  logic [NUM_CORES-1:0]   onehot;

  assign READY_O = rdy_q & CE_I;
  assign acc     = VALID_I & READY_O;

  // The outstanding cap also covers the slot whose result is currently being shifted out.
  assign can_dispatch = (in_state == HOLD) && !CORE_BUSY_I[wr_ptr] && !inflight[wr_ptr] &&
                        !pending[wr_ptr] && (outstanding != OUT_W'(NUM_CORES));
  assign dispatch     = CE_I & can_dispatch;
  assign onehot       = NUM_CORES'(1) << wr_ptr;
  assign CORE_START_O = dispatch ? onehot : '0;
  assign CORE_DATA_O  = dispatch ? blk : core_data_q;

  assign ser_load      = CE_I && (out_state == IDLE) && pending[rd_ptr];
  assign OUTSTANDING_O = outstanding;
  assign ERR_O         = err_q;

  always_ff @(posedge CLK_I or posedge RESET_I) begin
    if (RESET_I) begin
      in_state    <= FILL;
      out_state   <= IDLE;
      rdy_q       <= 1'b0;
      beat_cnt    <= '0;
      blk         <= '0;
      core_data_q <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      inflight    <= '0;
      pending     <= '0;
      err_q       <= 1'b0;
      outstanding <= '0;
      for (int i = 0; i < NUM_CORES; i++) slot[i] <= '0;
    end else if (CE_I) begin
      case (in_state)
        FILL: begin
          rdy_q <= 1'b1;
          if (acc) begin
            blk[beat_cnt*DATA_W +: DATA_W] <= DATA_I;
            if (beat_cnt == CNT_W'(BEATS - 1)) begin
              beat_cnt <= '0;
              rdy_q    <= 1'b0;
              in_state <= HOLD;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (can_dispatch) begin
            core_data_q <= blk;
            wr_ptr      <= (wr_ptr == PTR_W'(NUM_CORES - 1)) ? '0 : wr_ptr + 1'b1;
            rdy_q       <= 1'b1;
            in_state    <= FILL;
          end
        end
      endcase

      for (int i = 0; i < NUM_CORES; i++) begin
        if (CORE_DONE_I[i]) begin
          if (inflight[i]) begin
            slot[i]     <= CORE_RESULT_I[i*128 +: 128];
            inflight[i] <= 1'b0;
            pending[i]  <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
        end
      end
      if (dispatch) inflight[wr_ptr] <= 1'b1;
      if (ser_load) pending[rd_ptr] <= 1'b0;

      case (out_state)
        IDLE: if (pending[rd_ptr]) out_state <= SEND;
        SEND: begin
          if (ser_last) begin
            rd_ptr    <= (rd_ptr == PTR_W'(NUM_CORES - 1)) ? '0 : rd_ptr + 1'b1;
            out_state <= IDLE;
          end
        end
      endcase

      case ({dispatch, ser_last})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  aes_stream_ser #(.DATA_W(DATA_W)) u_ser (
    .clk   (CLK_I),
    .rst   (RESET_I),
    .ce    (CE_I),
    .load  (ser_load),
    .block (slot[rd_ptr]),
    .ready (READY_I),
    .data  (DATA_O),
    .valid (VALID_O),
    .last  (ser_last)
  );
endmodule

// File: tb/tb_aes_multicore_dispatch.sv
// Bench for aes_multicore_dispatch: model cores, random blocks, in-order result checking.
module tb_aes_multicore_dispatch;
  import aes_pkg::*;

  localparam int DW    = 8;
  localparam int NC    = 4;
  localparam int BEATS = 128 / DW;
  localparam block_t KEY = 128'h0123456789ABCDEF_FEDCBA9876543210;

  logic              clk = 1'b0;
  logic              rst, ce, vin, rdy_i;
  logic [DW-1:0]     din;
  logic              rdy_o, vout, err;
  logic [127:0]      cdata;
  logic [NC-1:0]     cstart, busy, done_m, spur;
  logic [NC*128-1:0] res_bus;
  logic [DW-1:0]     dout;
  logic [2:0]        outst;

  aes_multicore_dispatch #(.DATA_W(DW), .NUM_CORES(NC)) dut (
    .CLK_I(clk), .RESET_I(rst), .CE_I(ce), .DATA_I(din), .VALID_I(vin), .READY_O(rdy_o),
    .CORE_DATA_O(cdata), .CORE_START_O(cstart), .CORE_BUSY_I(busy), .CORE_DONE_I(done_m | spur),
    .CORE_RESULT_I(res_bus), .DATA_O(dout), .VALID_O(vout), .READY_I(rdy_i),
    .OUTSTANDING_O(outst), .ERR_O(err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic block_t core_fn(input block_t b);
    return {b[63:0], b[127:64]} ^ KEY;
  endfunction

  function automatic block_t rand_block();
    block_t r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Model cores: fixed per-core latency, busy while computing.
  int     lat [NC];
  int     ccnt [NC];
  block_t res [NC];
  for (genvar g = 0; g < NC; g++) begin : g_res
    assign res_bus[g*128 +: 128] = res[g];
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= '0;
      done_m <= '0;
      for (int i = 0; i < NC; i++) begin ccnt[i] <= 0; res[i] <= '0; end
    end else if (ce) begin
      for (int i = 0; i < NC; i++) begin
        done_m[i] <= 1'b0;
        if (cstart[i]) begin
          busy[i] <= 1'b1;
          ccnt[i] <= lat[i] - 1;
          res[i]  <= core_fn(cdata);
        end else if (busy[i]) begin
          if (ccnt[i] == 0) begin busy[i] <= 1'b0; done_m[i] <= 1'b1; end
          else ccnt[i] <= ccnt[i] - 1;
        end
      end
    end
  end

  // Start monitor
  logic [NC-1:0] st_q [$];
  block_t        sd_q [$];
  int            sc_q [$];
  always @(posedge clk) begin
    if (!rst && ce && cstart != '0) begin
      st_q.push_back(cstart);
      sd_q.push_back(cdata);
      sc_q.push_back(cyc);
    end
  end

  // Downstream ready generator: 0 = low, 1 = high, 2 = toggle
  int rdy_mode = 1;
  always @(negedge clk) begin
    #1;
    case (rdy_mode)
      0:       rdy_i = 1'b0;
      1:       rdy_i = 1'b1;
      default: rdy_i = ~rdy_i;
    endcase
  end

  // Output monitor: assembles beats into blocks and flags beats that change while stalled.
  block_t      out_q [$];
  block_t      beat_buf;
  int          nb = 0, hold_err = 0;
  logic        prev_stall = 1'b0;
  logic [DW-1:0] prev_d;
  always @(negedge clk) begin
    #2;
    if (rst) begin
      nb = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (vout !== 1'b1 || dout !== prev_d)) hold_err++;
      if (ce && vout && rdy_i) begin
        beat_buf[nb*DW +: DW] = dout;
        nb++;
        if (nb == BEATS) begin out_q.push_back(beat_buf); nb = 0; end
      end
      prev_stall = vout && !(ce && rdy_i);
      prev_d     = dout;
    end
  end

  // Reference: blocks in input order, and the round-robin dispatch count.
  block_t exp_q [$];
  block_t log_q [$];
  int     disp_total = 0;
  int     last_acc = 0;

  task automatic send_block(input block_t b, input int nbeats);
    if (nbeats == BEATS) begin exp_q.push_back(b); log_q.push_back(b); end
    for (int k = 0; k < nbeats; k++) begin
      int t = 0;
      #1;
      vin = 1'b1;
      din = b[k*DW +: DW];
      while (rdy_o !== 1'b1 && t < 3000) begin @(negedge clk); #1; t++; end
      if (rdy_o !== 1'b1) begin
        checks++; failures++;
        $display("FAIL send_timeout beat=%0d ready=%b required=1", k, rdy_o);
        vin = 1'b0;
        return;
      end
      if (k == nbeats - 1) last_acc = cyc;
      @(negedge clk);
    end
    vin = 1'b0;
  endtask

  task automatic wait_outputs(input int n);
    int t = 0;
    while (out_q.size() < n && t < 6000) begin @(negedge clk); t++; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    vin = 1'b0; spur = '0;
    exp_q.delete(); log_q.delete(); st_q.delete(); sd_q.delete(); sc_q.delete(); out_q.delete();
    disp_total = 0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (rdy_o !== 1'b0 || vout !== 1'b0 || cstart !== '0 || outst !== '0 || err !== 1'b0 || dout !== '0) begin
      failures++;
      $display("FAIL reset_outputs ready=%b valid=%b start=%b outst=%0d err=%b data=%h required all 0",
               rdy_o, vout, cstart, outst, err, dout);
    end
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (rdy_o !== 1'b1) begin failures++; $display("FAIL ready_after_reset got=%b required=1", rdy_o); end
  endtask

  task automatic test_basic();
    block_t b;
    logic [NC-1:0] e;
    for (int i = 0; i < NC; i++) lat[i] = 10;
    rdy_mode = 1;
    for (int k = 0; k < BEATS; k++) b[k*8 +: 8] = 8'(k);
    send_block(b, BEATS);
    repeat (3) @(negedge clk);
    checks++;
    if (st_q.size() != 1) begin
      failures++; $display("FAIL basic_start_count got=%0d required=1", st_q.size());
    end else begin
      e = NC'(1) << (disp_total % NC);
      checks++;
      if (st_q[0] !== e) begin failures++; $display("FAIL basic_start got=%b required=%b", st_q[0], e); end
      checks++;
      if (sc_q[0] != last_acc + 1) begin
        failures++; $display("FAIL basic_latency start_cyc=%0d required=%0d", sc_q[0], last_acc + 1);
      end
      checks++;
      if (sd_q[0] !== 128'h0F0E0D0C0B0A09080706050403020100) begin
        failures++; $display("FAIL basic_core_data got=%h required=%h", sd_q[0], 128'h0F0E0D0C0B0A09080706050403020100);
      end
      void'(st_q.pop_front()); void'(sd_q.pop_front()); void'(sc_q.pop_front());
      void'(log_q.pop_front());
      disp_total++;
    end
    wait_outputs(1);
    checks++;
    if (out_q.size() != 1) begin
      failures++; $display("FAIL basic_out_count got=%0d required=1", out_q.size());
    end else begin
      block_t got = out_q.pop_front();
      block_t exp = core_fn(exp_q.pop_front());
      checks++;
      if (got !== exp) begin failures++; $display("FAIL basic_out got=%h required=%h", got, exp); end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (outst !== 3'd0 || err !== 1'b0) begin
      failures++; $display("FAIL basic_idle outst=%0d err=%b required 0/0", outst, err);
    end
  endtask

  task automatic test_back_to_back();
    lat[0] = 40; lat[1] = 5; lat[2] = 20; lat[3] = 5;
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) send_block(rand_block(), BEATS);
    wait_outputs(8);
    checks++;
    if (st_q.size() != 8 || out_q.size() != 8) begin
      failures++; $display("FAIL b2b_counts starts=%0d outs=%0d required 8/8", st_q.size(), out_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        logic [NC-1:0] e = NC'(1) << (disp_total % NC);
        logic [NC-1:0] gs = st_q.pop_front();
        block_t gd = sd_q.pop_front();
        block_t ed = log_q.pop_front();
        block_t go = out_q.pop_front();
        block_t eo = core_fn(exp_q.pop_front());
        void'(sc_q.pop_front());
        disp_total++;
        checks += 3;
        if (gs !== e)  begin failures++; $display("FAIL b2b_start[%0d] got=%b required=%b", i, gs, e); end
        if (gd !== ed) begin failures++; $display("FAIL b2b_core_data[%0d] got=%h required=%h", i, gd, ed); end
        if (go !== eo) begin failures++; $display("FAIL b2b_out[%0d] got=%h required=%h", i, go, eo); end
      end
    end
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL b2b_err got=%b required=0", err); end
  endtask

  task automatic test_ready_toggle();
    for (int i = 0; i < NC; i++) lat[i] = 5;
    hold_err = 0;
    rdy_mode = 2;
    for (int i = 0; i < 3; i++) send_block(rand_block(), BEATS);
    wait_outputs(3);
    repeat (5) @(negedge clk);
    checks++;
    if (hold_err != 0) begin failures++; $display("FAIL toggle_hold violations=%0d required=0", hold_err); end
    checks++;
    if (out_q.size() != 3 || nb != 0) begin
      failures++; $display("FAIL toggle_beats blocks=%0d partial=%0d required 3/0", out_q.size(), nb);
    end
    for (int i = 0; i < 3 && out_q.size() > 0; i++) begin
      block_t go = out_q.pop_front();
      block_t eo = core_fn(exp_q.pop_front());
      checks++;
      if (go !== eo) begin failures++; $display("FAIL toggle_out[%0d] got=%h required=%h", i, go, eo); end
    end
    st_q.delete(); sd_q.delete(); sc_q.delete(); log_q.delete();
    disp_total += 3;
    rdy_mode = 1;
  endtask

  task automatic test_full();
    for (int i = 0; i < NC; i++) lat[i] = 5;
    rdy_mode = 0;
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 6; i++) send_block(rand_block(), BEATS);
      end
      begin
        repeat (300) @(negedge clk);
        #3;
        checks++;
        if (rdy_o !== 1'b0 || outst !== 3'd4 || st_q.size() != 4 || vout !== 1'b1) begin
          failures++;
          $display("FAIL full_stall ready=%b outst=%0d starts=%0d valid=%b required 0/4/4/1",
                   rdy_o, outst, st_q.size(), vout);
        end
        rdy_mode = 1;
      end
    join
    wait_outputs(6);
    repeat (4) @(negedge clk);
    checks++;
    if (out_q.size() != 6 || st_q.size() != 6) begin
      failures++; $display("FAIL full_counts outs=%0d starts=%0d required 6/6", out_q.size(), st_q.size());
    end
    for (int i = 0; i < 6 && out_q.size() > 0 && st_q.size() > 0; i++) begin
      logic [NC-1:0] e = NC'(1) << (disp_total % NC);
      logic [NC-1:0] gs = st_q.pop_front();
      block_t go = out_q.pop_front();
      block_t eo = core_fn(exp_q.pop_front());
      disp_total++;
      checks += 2;
      if (gs !== e)  begin failures++; $display("FAIL full_start[%0d] got=%b required=%b", i, gs, e); end
      if (go !== eo) begin failures++; $display("FAIL full_out[%0d] got=%h required=%h", i, go, eo); end
    end
    sd_q.delete(); sc_q.delete(); log_q.delete();
    checks++;
    if (outst !== 3'd0) begin failures++; $display("FAIL full_drained outst=%0d required=0", outst); end
  endtask

  task automatic test_ce();
    logic          v;
    logic [DW-1:0] d;
    int            t = 0;
    for (int i = 0; i < NC; i++) lat[i] = 3;
    rdy_mode = 1;
    send_block(rand_block(), BEATS);
    forever begin
      @(negedge clk); #1;
      if (nb >= 5 || t > 500) break;
      t++;
    end
    ce = 1'b0;
    v = vout;
    d = dout;
    checks++;
    if (v !== 1'b1) begin failures++; $display("FAIL ce_midstream valid=%b required=1", v); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #3;
      checks++;
      if (vout !== v || dout !== d || rdy_o !== 1'b0 || cstart !== '0) begin
        failures++;
        $display("FAIL ce_hold valid=%b data=%h ready=%b start=%b required %b/%h/0/0", vout, dout, rdy_o, cstart, v, d);
      end
    end
    @(negedge clk); #1 ce = 1'b1;
    wait_outputs(1);
    checks++;
    if (out_q.size() != 1) begin
      failures++; $display("FAIL ce_out_count got=%0d required=1", out_q.size());
    end else begin
      block_t go = out_q.pop_front();
      block_t eo = core_fn(exp_q.pop_front());
      checks++;
      if (go !== eo) begin failures++; $display("FAIL ce_out got=%h required=%h", go, eo); end
    end
    st_q.delete(); sd_q.delete(); sc_q.delete(); log_q.delete();
    disp_total++;
  endtask

  task automatic test_spurious();
    @(negedge clk); #1 spur = 4'b0100;
    @(negedge clk); #1 spur = '0;
    @(negedge clk); #3;
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL spurious_err got=%b required=1", err); end
    repeat (20) @(negedge clk);
    #3;
    checks++;
    if (err !== 1'b1 || vout !== 1'b0 || out_q.size() != 0 || outst !== 3'd0) begin
      failures++;
      $display("FAIL spurious_sticky err=%b valid=%b outs=%0d outst=%0d required 1/0/0/0", err, vout, out_q.size(), outst);
    end
    do_reset();
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL spurious_reset_clear got=%b required=0", err); end
  endtask

  task automatic test_mid_reset();
    block_t b;
    for (int i = 0; i < NC; i++) lat[i] = 10;
    send_block(rand_block(), 7);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (rdy_o !== 1'b0 || vout !== 1'b0) begin
      failures++; $display("FAIL midreset_outputs ready=%b valid=%b required 0/0", rdy_o, vout);
    end
    exp_q.delete(); log_q.delete(); st_q.delete(); sd_q.delete(); sc_q.delete(); out_q.delete();
    disp_total = 0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    b = rand_block();
    send_block(b, BEATS);
    wait_outputs(1);
    checks++;
    if (st_q.size() != 1 || out_q.size() != 1) begin
      failures++; $display("FAIL midreset_counts starts=%0d outs=%0d required 1/1", st_q.size(), out_q.size());
    end else begin
      logic [NC-1:0] gs = st_q.pop_front();
      block_t gd = sd_q.pop_front();
      block_t go = out_q.pop_front();
      checks += 3;
      if (gs !== 4'b0001) begin failures++; $display("FAIL midreset_start got=%b required=0001", gs); end
      if (gd !== b)       begin failures++; $display("FAIL midreset_core_data got=%h required=%h", gd, b); end
      if (go !== core_fn(b)) begin failures++; $display("FAIL midreset_out got=%h required=%h", go, core_fn(b)); end
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; vin = 1'b0; din = '0; spur = '0; rdy_i = 1'b0;
    for (int i = 0; i < NC; i++) lat[i] = 10;
    test_reset();
    test_basic();
    test_back_to_back();
    test_ready_toggle();
    test_full();
    test_ce();
    test_spurious();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
